// File: rtl/rv32_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv32_pkg : shared fetch-path types and constants   | Rev 1.0       |
// +--------------------------------------------------------------------+
package rv32_pkg;
  localparam int XLEN         = 32;
  localparam int ILEN         = 32;
  localparam int CREDIT_DEPTH = 2;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [ILEN-1:0] instr_t;

  localparam addr_t  RESET_PC_DEFAULT = 32'h0000_0000;
  localparam instr_t NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    addr_t  pc;
    instr_t opcode;
  } fetch_entry_t;

  function automatic logic is_aligned(input addr_t a);
    return a[1:0] == 2'b00;
  endfunction
endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_fifo : 2-entry registered FIFO with flush    | Rev 1.0       |
// +--------------------------------------------------------------------+
module fetch_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop  && (r_count != 2'd0);
  assign w_push = i_push && (r_count != 2'd2);

  // Flush wins over a same-cycle push or pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch : credit-limited fetch with redirect   | Rev 1.0       |
// +--------------------------------------------------------------------+
module instr_fetch
  import rv32_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [ILEN-1:0] i_imem_rsp_data,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_addr,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [ILEN-1:0] o_opcode,
  output logic [XLEN-1:0] o_pc,
  output logic            o_misaligned
);
  localparam logic [2:0] CREDIT_LIMIT = 3'(CREDIT_DEPTH);

  addr_t        r_pc;
  logic [1:0]   r_drop;
  logic         r_mis;

  logic         w_pend_valid;
  addr_t        w_pend_pc;
  logic [1:0]   w_pend_count;
  logic         w_out_valid;
  fetch_entry_t w_out_entry;
  logic [1:0]   w_out_count;
  logic [2:0]   w_used;
  logic [2:0]   w_inflight;
  logic         w_req_fire;
  logic         w_rsp_live;
  logic         w_mis_shown;

  // Credit counts only registered occupancy, so a pop frees a slot one cycle later.
  assign w_used = {1'b0, w_pend_count} + {1'b0, r_drop} + {1'b0, w_out_count};
  assign o_imem_req_valid = i_rst_n && !r_mis && (w_used < CREDIT_LIMIT);
  assign o_imem_addr      = r_pc;
  assign w_req_fire       = o_imem_req_valid && i_imem_req_ready;
  assign w_rsp_live       = i_imem_rsp_valid && (r_drop == 2'd0) && w_pend_valid;

  // Everything still in flight after this cycle becomes stale on a redirect.
  assign w_inflight = {1'b0, r_drop} + {1'b0, w_pend_count}
                    + {2'b00, w_req_fire} - {2'b00, i_imem_rsp_valid};

  fetch_fifo #(.WIDTH(XLEN)) u_pend_q (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect),
    .i_push  (w_req_fire),
    .i_data  (r_pc),
    .i_pop   (w_rsp_live),
    .o_valid (w_pend_valid),
    .o_data  (w_pend_pc),
    .o_count (w_pend_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t))) u_out_q (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect),
    .i_push  (w_rsp_live),
    .i_data  ({w_pend_pc, i_imem_rsp_data}),
    .i_pop   (i_ready && !r_mis),
    .o_valid (w_out_valid),
    .o_data  (w_out_entry),
    .o_count (w_out_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc   <= RESET_PC;
      r_drop <= 2'd0;
      r_mis  <= 1'b0;
    end else if (i_redirect) begin
      r_pc   <= i_redirect_addr;
      r_drop <= w_inflight[1:0];
      r_mis  <= !is_aligned(i_redirect_addr);
    end else begin
      if (w_req_fire) begin
        r_pc <= r_pc + 32'd4;
      end
      if (i_imem_rsp_valid && (r_drop != 2'd0)) begin
        r_drop <= r_drop - 2'd1;
      end
    end
  end

  // A misaligned target is reported only once its stale responses have drained.
  assign w_mis_shown  = r_mis && (r_drop == 2'd0);
  assign o_valid      = r_mis ? w_mis_shown : w_out_valid;
  assign o_misaligned = w_mis_shown;
  assign o_pc         = r_mis ? r_pc      : w_out_entry.pc;
  assign o_opcode     = r_mis ? NOP_INSTR : w_out_entry.opcode;
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_fetch : scoreboard bench for instr_fetch  | Rev 1.0       |
// +--------------------------------------------------------------------+
module tb_instr_fetch;
  import rv32_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect;
  logic [31:0] i_redirect_addr;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_opcode;
  logic [31:0] o_pc;
  logic        o_misaligned;

  always #5 i_clk = ~i_clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_redirect       (i_redirect),
    .i_redirect_addr  (i_redirect_addr),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_opcode         (o_opcode),
    .o_pc             (o_pc),
    .o_misaligned     (o_misaligned)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] op; } exp_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  exp_t        exp_q[$];
  rsp_t        mem_q[$];
  int          checks = 0;
  int          failures = 0;
  int          delivered = 0;
  int          lat = 1;
  int          cyc = 0;
  int          fires = 0;
  int          xfers = 0;
  bit          occ_en = 1'b0;
  logic [31:0] exp_req = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic push_stream(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back('{pc: base + 32'(4 * k), op: mem_word(base + 32'(4 * k))});
  endtask

  task automatic wait_delivered(input int target, input int budget, input string name);
    int t;
    t = 0;
    while (delivered < target && t < budget) begin
      tick(1);
      t++;
    end
    checks++;
    if (delivered < target) begin
      failures++;
      $display("FAIL %s: delivered %0d expected at least %0d", name, delivered, target);
    end
  endtask

  // Memory model: in-order responses, fixed latency of lat cycles.
  initial begin
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = 32'h0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_imem_req_valid && i_imem_req_ready)
        mem_q.push_back('{due: cyc + lat, data: mem_word(o_imem_addr)});
      @(posedge i_clk);
      #1;
      cyc++;
      if (!i_rst_n) mem_q.delete();
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = mem_q[0].data;
        void'(mem_q.pop_front());
      end else begin
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'h0;
      end
    end
  end

  // Decoder-side scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_valid && i_ready && !o_misaligned) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got pc %h with no expected entry", o_pc);
        end else begin
          e = exp_q.pop_front();
          check32("sb_pc", o_pc, e.pc);
          check32("sb_opcode", o_opcode, e.op);
          delivered++;
        end
      end
    end
  end

  // Request-side model: address stable until accepted, +4 per acceptance.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        exp_req = 32'h0;
      end else begin
        if (o_imem_req_valid) check32("req_addr", o_imem_addr, exp_req);
        if (o_imem_req_valid && i_imem_req_ready) exp_req = exp_req + 32'd4;
        if (i_redirect) exp_req = i_redirect_addr;
      end
    end
  end

  // Outstanding + buffered occupancy, valid while no redirect has occurred.
  initial begin
    int occ;
    forever begin
      @(negedge i_clk);
      occ = fires + int'(o_imem_req_valid && i_imem_req_ready) - xfers;
      if (occ_en) begin
        checks++;
        if (occ > 2) begin
          failures++;
          $display("FAIL credit: occupancy %0d expected at most 2", occ);
        end
      end
      if (i_rst_n && o_imem_req_valid && i_imem_req_ready) fires++;
      if (i_rst_n && o_valid && i_ready) xfers++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    i_rst_n          = 1'b0;
    i_imem_req_ready = 1'b1;
    i_ready          = 1'b1;
    i_redirect       = 1'b0;
    i_redirect_addr  = 32'h0;
    tick(3);
    check32("rst_req_valid", 32'(o_imem_req_valid), 32'h0);
    check32("rst_valid", 32'(o_valid), 32'h0);
    check32("rst_misaligned", 32'(o_misaligned), 32'h0);
    check32("rst_opcode", o_opcode, 32'h0);
    check32("rst_pc", o_pc, 32'h0);

    // Boot stream: 0x0, 0x4, 0x8 ...
    push_stream(32'h0, 200);
    i_rst_n = 1'b1;
    occ_en  = 1'b1;
    wait_delivered(3, 20, "boot");

    // Decoder stall for 10 cycles.
    i_ready = 1'b0;
    tick(10);
    check32("stall_valid", 32'(o_valid), 32'h1);
    check32("stall_req_valid", 32'(o_imem_req_valid), 32'h0);
    i_ready = 1'b1;
    wait_delivered(delivered + 6, 30, "stall_resume");

    // Memory stall for 5 cycles.
    i_imem_req_ready = 1'b0;
    tick(5);
    check32("memstall_req_valid", 32'(o_imem_req_valid), 32'h1);
    i_imem_req_ready = 1'b1;
    wait_delivered(delivered + 4, 30, "memstall_resume");
    occ_en = 1'b0;

    // Redirect to 0x100 with responses in flight.
    lat = 3;
    tick(8);
    t = 0;
    @(negedge i_clk);
    while (!(o_imem_req_valid && i_imem_req_ready) && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    @(posedge i_clk);
    #1;
    i_ready         = 1'b0;
    i_redirect      = 1'b1;
    i_redirect_addr = 32'h0000_0100;
    exp_q.delete();
    push_stream(32'h0000_0100, 100);
    tick(1);
    i_redirect = 1'b0;
    check32("redir_flush_valid", 32'(o_valid), 32'h0);
    i_ready = 1'b1;
    wait_delivered(delivered + 3, 60, "redir_0x100");

    // Misaligned redirect to 0x102, then recovery at 0x200.
    i_ready         = 1'b0;
    i_redirect      = 1'b1;
    i_redirect_addr = 32'h0000_0102;
    exp_q.delete();
    tick(1);
    i_redirect = 1'b0;
    t = 0;
    while (!o_valid && t < 20) begin
      tick(1);
      t++;
    end
    check32("mis_valid", 32'(o_valid), 32'h1);
    check32("mis_flag", 32'(o_misaligned), 32'h1);
    check32("mis_pc", o_pc, 32'h0000_0102);
    check32("mis_opcode", o_opcode, 32'h0000_0013);
    check32("mis_req_valid", 32'(o_imem_req_valid), 32'h0);
    i_ready = 1'b1;
    tick(3);
    check32("mis_hold_valid", 32'(o_valid), 32'h1);
    check32("mis_hold_flag", 32'(o_misaligned), 32'h1);
    i_ready         = 1'b0;
    i_redirect      = 1'b1;
    i_redirect_addr = 32'h0000_0200;
    push_stream(32'h0000_0200, 100);
    tick(1);
    i_redirect = 1'b0;
    check32("mis_cleared", 32'(o_misaligned), 32'h0);
    i_ready = 1'b1;
    wait_delivered(delivered + 3, 60, "redir_0x200");

    // Asynchronous reset mid-stream, then restart at RESET_PC.
    lat = 1;
    tick(6);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check32("arst_req_valid", 32'(o_imem_req_valid), 32'h0);
    check32("arst_valid", 32'(o_valid), 32'h0);
    check32("arst_misaligned", 32'(o_misaligned), 32'h0);
    check32("arst_opcode", o_opcode, 32'h0);
    check32("arst_pc", o_pc, 32'h0);
    exp_q.delete();
    push_stream(32'h0, 100);
    tick(3);
    i_rst_n = 1'b1;
    wait_delivered(delivered + 3, 20, "restart");

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have i_clk  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have o_imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have i_imem_req_ready  input  1  memory accepts request; transfer when valid&&ready.
REQ-006 SHALL have o_imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have i_imem_rsp_valid  input  1  instruction word returned; in order, one per accepted request, latency >=1 cycle, no backpressure.
REQ-008 SHALL have i_imem_rsp_data  input  32  returned instruction word.
REQ-009 SHALL have i_redirect  input  1  one-cycle pulse: change fetch stream (jump/branch taken).
REQ-010 SHALL have i_redirect_addr  input  32  new fetch address, sampled when i_redirect=1.
REQ-011 SHALL have o_valid  output  1  o_opcode/o_pc hold an instruction for the decoder.
REQ-012 SHALL have i_ready  input  1  decoder accepts; transfer when o_valid&&i_ready.
REQ-013 SHALL have o_opcode  output  32  instruction word to the decoder's i_opcode.
REQ-014 SHALL have o_pc  output  32  address of o_opcode, to the decoder's i_pc.
REQ-015 SHALL have o_misaligned  output  1  redirect target not 4-byte aligned.

Function
REQ-016 SHALL hold fetch PC; o_imem_addr = fetch PC; PC += 4 on each accepted request (wraps 32'hFFFF_FFFC -> 0).
REQ-017 SHALL assert o_imem_req_valid only when outstanding + buffered < 2 (credit limit 2); a pop in the same cycle does not free credit until the next cycle.
REQ-018 SHALL keep o_imem_req_valid and o_imem_addr stable while valid && !ready.
REQ-019 SHALL record the PC of each accepted request in a 2-entry in-order pending queue.
REQ-020 SHALL push each live response with its pending PC into a 2-entry output FIFO; o_valid = FIFO non-empty, from registers; response in cycle N visible at cycle N+1.
REQ-021 SHALL pop the FIFO head on o_valid&&i_ready; simultaneous push and pop at count 1 keeps count 1 and the order.
REQ-022 SHALL never overflow the FIFO or drop a live response, given REQ-017.
REQ-023 On i_redirect: fetch PC <= i_redirect_addr; FIFO flushed (o_valid=0 next cycle); every response still outstanding, including a request accepted in the redirect cycle, is marked stale and discarded on return.
REQ-024 SHALL track stale responses with a 0..2 drop counter that takes priority over FIFO push.
REQ-025 A redirect in the same cycle as a pop or push SHALL take precedence; the popped instruction is considered consumed.
REQ-026 If i_redirect_addr[1:0] != 0: stop requesting; after the outstanding responses drain, present o_valid=1, o_misaligned=1, o_pc=i_redirect_addr, o_opcode=32'h0000_0013 (NOP); hold until the next redirect.
REQ-027 SHALL cancel a pending misaligned state on the next aligned redirect.

Reset
REQ-028 While i_rst_n=0: fetch PC=RESET_PC; counters, queues and the drop counter are cleared.
REQ-029 While i_rst_n=0: o_imem_req_valid=0, o_valid=0, o_misaligned=0, o_opcode=0, o_pc=0.
REQ-030 First request SHALL issue the first rising edge after release, addr=RESET_PC.
REQ-031 After reset mid-operation, responses to pre-reset requests are the memory's responsibility to suppress.

Structure
REQ-032 Package rv32_pkg SHALL hold RESET_PC default, XLEN=32, ILEN=32, NOP encoding 32'h0000_0013, credit depth 2.
REQ-033 SHALL instantiate one sub-module fetch_fifo (2-entry, registered, flushable) for the output FIFO; the pending-PC queue is a second instance.

Verification
REQ-034 Reset release, ready=1, 1-cycle latency -> requests 0x0,0x4,0x8; decoder sees pc 0x0,0x4,0x8 in order.
REQ-035 i_ready=0 for 10 cycles -> at most 2 requests outstanding/buffered, no loss; resume with pc sequence contiguous.
REQ-036 Redirect to 0x100 with 2 responses outstanding -> both discarded, next o_pc=0x100, then 0x104.
REQ-037 Redirect to 0x102 -> o_valid=1, o_misaligned=1, o_pc=0x102, o_opcode=0x13; redirect to 0x200 clears it.
REQ-038 i_imem_req_ready=0 for 5 cycles -> o_imem_addr held stable; fetch PC advances only on acceptance.
REQ-039 Async reset asserted mid-stream -> all outputs 0 immediately; restart at RESET_PC.
